// File: rtl/fdma_ctr_dac.sv
// FDMA read-side controller: fetches packets from a ring of DDR buffers into a local FIFO for a stream sink.
// Define FDMA_RD_LOOP_EN to ignore buf_valid_i and replay the buffer ring forever.
module fdma_ctr_dac #(
  parameter int ADDR_OFFSET    = 0,
  parameter int AXI_BURST_LEN  = 8,
  parameter int AXI_DATA_WIDTH = 128,
  parameter int FDMA_BUF_SIZE  = 2,
  parameter int FDMA_BUF_LEN   = 32,
  parameter int FIFO_DEPTH     = 32
) (
  input  logic                          ui_clk,
  input  logic                          ui_rstn,
  input  logic [FDMA_BUF_SIZE-1:0]      buf_valid_i,
  output logic                          pkg_rd_areq,
  input  logic                          pkg_rd_en,
  input  logic                          pkg_rd_last,
  output logic [31:0]                   pkg_rd_addr,
  input  logic [AXI_DATA_WIDTH-1:0]     pkg_rd_data,
  output logic [31:0]                   pkg_rd_size,
  input  logic                          R0_rden_i,
  output logic [AXI_DATA_WIDTH-1:0]     R0_data_o,
  output logic                          R0_empty_o,
  output logic [$clog2(FIFO_DEPTH):0]   R0_rcnt_o,
  output logic [FDMA_BUF_SIZE-1:0]      xdma_irq_req,
  output logic [1:0]                    err_o
);

  localparam int PKG_SIZE    = AXI_BURST_LEN;
  localparam int BURST_SIZE  = AXI_BURST_LEN * AXI_DATA_WIDTH / 8;
  localparam int BURST_TIMES = FDMA_BUF_LEN / (BURST_SIZE / 4);
  localparam int AW          = $clog2(FIFO_DEPTH);
  localparam int FBW         = (FDMA_BUF_SIZE > 1) ? $clog2(FDMA_BUF_SIZE) : 1;
  localparam int BCW         = $clog2(BURST_TIMES + 1);
  localparam logic [FDMA_BUF_SIZE-1:0] IRQ_ONE = 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_REQ, S_DATA} state_t;

  state_t                    state;
  logic [FBW-1:0]            R0_Fbuf;
  logic [13:0]               R0_addr;
  logic [BCW-1:0]            R0_bcnt;
  logic [BCW-1:0]            bcnt_nxt;
  logic [FDMA_BUF_SIZE-1:0]  buf_ready;
  logic                      space_ok;

  logic [AXI_DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]             wptr;
  logic [AW-1:0]             rptr;
  logic [AW:0]               fifo_cnt;
  logic                      fifo_full;
  logic                      wr_acc;
  logic                      rd_acc;

`ifdef FDMA_RD_LOOP_EN
  assign buf_ready = buf_valid_i | {FDMA_BUF_SIZE{1'b1}};
`else
  assign buf_ready = buf_valid_i;
`endif

  assign pkg_rd_addr = {11'd0, 7'(R0_Fbuf), R0_addr} + 32'(ADDR_OFFSET);
  assign pkg_rd_size = 32'(PKG_SIZE);
  assign bcnt_nxt    = R0_bcnt + 1'b1;
  // Only one packet is ever in flight, so a full packet of free space rules out overflow.
  assign space_ok    = fifo_cnt <= (AW+1)'(FIFO_DEPTH - PKG_SIZE);

  always_ff @(posedge ui_clk or negedge ui_rstn) begin
    if (!ui_rstn) begin
      state        <= S_IDLE;
      R0_Fbuf      <= '0;
      R0_addr      <= '0;
      R0_bcnt      <= '0;
      pkg_rd_areq  <= 1'b0;
      xdma_irq_req <= '0;
    end else begin
      pkg_rd_areq  <= 1'b0;
      xdma_irq_req <= '0;
      case (state)
        S_IDLE: begin
          R0_addr <= '0;
          R0_bcnt <= '0;
          state   <= S_WAIT;
        end
        S_WAIT: begin
          if (buf_ready[R0_Fbuf] && space_ok) begin
            pkg_rd_areq <= 1'b1;
            state       <= S_REQ;
          end
        end
        S_REQ: state <= S_DATA;
        S_DATA: begin
          if (pkg_rd_last) begin
            R0_bcnt <= bcnt_nxt;
            R0_addr <= R0_addr + 14'(BURST_SIZE);
            if (bcnt_nxt == BCW'(BURST_TIMES)) begin
              xdma_irq_req <= IRQ_ONE << R0_Fbuf;
              R0_Fbuf      <= (R0_Fbuf == FBW'(FDMA_BUF_SIZE - 1)) ? '0 : R0_Fbuf + 1'b1;
              state        <= S_IDLE;
            end else begin
              state <= S_WAIT;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign fifo_full  = fifo_cnt == (AW+1)'(FIFO_DEPTH);
  assign R0_empty_o = fifo_cnt == '0;
  assign R0_rcnt_o  = fifo_cnt;
  // Beats are accepted regardless of FSM state; only a full FIFO drops them.
  assign wr_acc     = pkg_rd_en && !fifo_full;
  assign rd_acc     = R0_rden_i && !R0_empty_o;

  always_ff @(posedge ui_clk) begin
    if (wr_acc) mem[wptr] <= pkg_rd_data;
  end

  always_ff @(posedge ui_clk or negedge ui_rstn) begin
    if (!ui_rstn) begin
      wptr      <= '0;
      rptr      <= '0;
      fifo_cnt  <= '0;
      R0_data_o <= '0;
      err_o     <= '0;
    end else begin
      if (wr_acc) wptr <= wptr + 1'b1;
      if (rd_acc) begin
        rptr      <= rptr + 1'b1;
        R0_data_o <= mem[rptr];
      end
      case ({wr_acc, rd_acc})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
      if (pkg_rd_en && fifo_full)   err_o[0] <= 1'b1;
      if (R0_rden_i && R0_empty_o)  err_o[1] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fdma_ctr_dac.sv
// Directed bench for fdma_ctr_dac in its default build: buffer gating, FIFO data/flags, errors, reset mid-burst.
module tb_fdma_ctr_dac;

  logic         ui_clk;
  logic         ui_rstn;
  logic [1:0]   buf_valid_i;
  logic         pkg_rd_areq;
  logic         pkg_rd_en;
  logic         pkg_rd_last;
  logic [31:0]  pkg_rd_addr;
  logic [127:0] pkg_rd_data;
  logic [31:0]  pkg_rd_size;
  logic         R0_rden_i;
  logic [127:0] R0_data_o;
  logic         R0_empty_o;
  logic [5:0]   R0_rcnt_o;
  logic [1:0]   xdma_irq_req;
  logic [1:0]   err_o;

  int checks   = 0;
  int failures = 0;
  bit found;

  fdma_ctr_dac dut (
    .ui_clk       (ui_clk),
    .ui_rstn      (ui_rstn),
    .buf_valid_i  (buf_valid_i),
    .pkg_rd_areq  (pkg_rd_areq),
    .pkg_rd_en    (pkg_rd_en),
    .pkg_rd_last  (pkg_rd_last),
    .pkg_rd_addr  (pkg_rd_addr),
    .pkg_rd_data  (pkg_rd_data),
    .pkg_rd_size  (pkg_rd_size),
    .R0_rden_i    (R0_rden_i),
    .R0_data_o    (R0_data_o),
    .R0_empty_o   (R0_empty_o),
    .R0_rcnt_o    (R0_rcnt_o),
    .xdma_irq_req (xdma_irq_req),
    .err_o        (err_o)
  );

  initial ui_clk = 1'b0;
  always #5 ui_clk = ~ui_clk;

  function automatic logic [127:0] beat(input int i);
    return {64'd0, 32'hA5A5, 32'(i)};
  endfunction

  task automatic check_output(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_areq(input int max_cycles, output bit seen);
    seen = 1'b0;
    for (int c = 0; c < max_cycles && !seen; c++) begin
      @(negedge ui_clk);
      if (pkg_rd_areq) seen = 1'b1;
    end
  endtask

  // Eight beats starting at the negedge where the request was observed.
  task automatic apply_stimulus(input int first, input logic [1:0] exp_irq, input logic [5:0] exp_cnt);
    for (int i = 0; i < 8; i++) begin
      pkg_rd_en   = 1'b1;
      pkg_rd_data = beat(first + i);
      pkg_rd_last = (i == 7);
      @(negedge ui_clk);
      if (i == 0) check_output("areq_one_cycle", pkg_rd_areq, 1'b0);
    end
    pkg_rd_en   = 1'b0;
    pkg_rd_last = 1'b0;
    check_output("irq_pulse", xdma_irq_req, exp_irq);
    check_output("rcnt_after_pkt", R0_rcnt_o, exp_cnt);
    @(negedge ui_clk);
    check_output("irq_cleared", xdma_irq_req, 2'b00);
  endtask

  task automatic read_words(input int first);
    R0_rden_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge ui_clk);
      check_output($sformatf("rd_data_%0d", first + i), R0_data_o, beat(first + i));
    end
    R0_rden_i = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, "_areq"},  pkg_rd_areq,  1'b0);
    check_output({tag, "_addr"},  pkg_rd_addr,  32'h0);
    check_output({tag, "_irq"},   xdma_irq_req, 2'b00);
    check_output({tag, "_data"},  R0_data_o,    128'h0);
    check_output({tag, "_empty"}, R0_empty_o,   1'b1);
    check_output({tag, "_rcnt"},  R0_rcnt_o,    6'd0);
    check_output({tag, "_err"},   err_o,        2'b00);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    ui_rstn     = 1'b0;
    buf_valid_i = 2'b00;
    pkg_rd_en   = 1'b0;
    pkg_rd_last = 1'b0;
    pkg_rd_data = '0;
    R0_rden_i   = 1'b0;
    repeat (3) @(negedge ui_clk);
    check_reset_values("reset");
    check_output("pkg_size", pkg_rd_size, 32'd8);

    // Only buffer 0 ready: one packet, then stall on buffer 1.
    ui_rstn     = 1'b1;
    buf_valid_i = 2'b01;
    wait_areq(10, found);
    check_output("areq_buf0", found, 1'b1);
    check_output("addr_buf0", pkg_rd_addr, 32'h0);
    apply_stimulus(0, 2'b01, 6'd8);
    wait_areq(8, found);
    check_output("no_areq_buf1_invalid", found, 1'b0);
    check_output("addr_next", pkg_rd_addr, 32'h4000);

    // Both ready, no reads: fill the FIFO to 32 and stall.
    buf_valid_i = 2'b11;
    wait_areq(4, found);
    check_output("areq_p1", found, 1'b1);
    check_output("addr_p1", pkg_rd_addr, 32'h4000);
    apply_stimulus(8, 2'b10, 6'd16);
    wait_areq(4, found);
    check_output("areq_p2", found, 1'b1);
    check_output("addr_p2", pkg_rd_addr, 32'h0);
    apply_stimulus(16, 2'b01, 6'd24);
    wait_areq(4, found);
    check_output("areq_p3", found, 1'b1);
    check_output("addr_p3", pkg_rd_addr, 32'h4000);
    apply_stimulus(24, 2'b10, 6'd32);
    wait_areq(8, found);
    check_output("no_areq_full", found, 1'b0);
    check_output("rcnt_full", R0_rcnt_o, 6'd32);
    check_output("empty_when_full", R0_empty_o, 1'b0);

    // Stray beat while full is dropped and flagged.
    pkg_rd_en   = 1'b1;
    pkg_rd_data = beat(999);
    @(negedge ui_clk);
    pkg_rd_en = 1'b0;
    check_output("err_overflow", err_o, 2'b01);
    check_output("rcnt_hold_full", R0_rcnt_o, 6'd32);

    read_words(0);
    check_output("rcnt_after_reads", R0_rcnt_o, 6'd24);
    wait_areq(2, found);
    check_output("areq_after_drain", found, 1'b1);
    check_output("addr_after_drain", pkg_rd_addr, 32'h0);

    // Reset in the middle of the data phase, after three beats.
    for (int i = 0; i < 3; i++) begin
      pkg_rd_en   = 1'b1;
      pkg_rd_data = beat(32 + i);
      @(negedge ui_clk);
    end
    pkg_rd_en = 1'b0;
    check_output("rcnt_mid_burst", R0_rcnt_o, 6'd27);
    ui_rstn = 1'b0;
    #1;
    check_reset_values("midreset");
    @(negedge ui_clk);
    ui_rstn     = 1'b1;
    buf_valid_i = 2'b01;
    wait_areq(10, found);
    check_output("areq_after_reset", found, 1'b1);
    check_output("addr_after_reset", pkg_rd_addr, 32'h0);
    apply_stimulus(100, 2'b01, 6'd8);

    // Drain, then read once more while empty.
    read_words(100);
    check_output("empty_after_drain", R0_empty_o, 1'b1);
    R0_rden_i = 1'b1;
    @(negedge ui_clk);
    R0_rden_i = 1'b0;
    check_output("err_underrun", err_o, 2'b10);
    check_output("data_hold_underrun", R0_data_o, beat(107));
    check_output("rcnt_hold_empty", R0_rcnt_o, 6'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fdma_ctr_dac.md
# fdma_ctr_dac

FDMA read-side controller. It fetches fixed-size packets from a ring of DDR frame buffers through the FDMA read channel and buffers them in an internal single-clock FIFO. A downstream consumer, typically a DAC/stream sink in the `ui_clk` domain, drains that FIFO. It is the read counterpart of the ADC write controller: same buffer layout, same address map, same packet size. It raises a per-buffer interrupt pulse when a buffer has been fully consumed.

## Interface
Parameters:
- `ADDR_OFFSET`, 0: byte base address added to every read address.
- `AXI_BURST_LEN`, 8: beats per FDMA packet (`PKG_SIZE`).
- `AXI_DATA_WIDTH`, 128: beat width in bits. Fixed at 128 for this revision.
- `FDMA_BUF_SIZE`, 2: number of ring buffers, range 1..4.
- `FDMA_BUF_LEN`, 32: buffer length in 32-bit words. Must be a multiple of `BURST_SIZE/4`.
- `FIFO_DEPTH`, 32: internal FIFO depth in beats. Must be a power of 2 and ≥ 2*`AXI_BURST_LEN`.

Derived values:
- `BURST_SIZE` = `AXI_BURST_LEN`*`AXI_DATA_WIDTH`/8 bytes.
- `BURST_TIMES` = `FDMA_BUF_LEN`/(`BURST_SIZE`/4).

Ports:
- `ui_clk` in 1: the only clock.
- `ui_rstn` in 1: asynchronous, active-low reset.
- `buf_valid_i` in `FDMA_BUF_SIZE`: level, one bit per buffer. 1 means buffer k holds data ready to read.
- `pkg_rd_areq` out 1: one-cycle packet read request.
- `pkg_rd_en` in 1: FDMA beat strobe. `pkg_rd_data` is valid in the same cycle.
- `pkg_rd_last` in 1: coincides with the last `pkg_rd_en` of the packet.
- `pkg_rd_addr` out 32: packet byte address.
- `pkg_rd_data` in 128: read beat.
- `pkg_rd_size` out 32: constant `PKG_SIZE`.
- `R0_rden_i` in 1: consumer read strobe.
- `R0_data_o` out 128: FIFO output, registered.
- `R0_empty_o` out 1: FIFO empty.
- `R0_rcnt_o` out `$clog2(FIFO_DEPTH)+1`: FIFO occupancy.
- `xdma_irq_req` out `FDMA_BUF_SIZE`: one-hot, 1-cycle pulse when buffer k is consumed.
- `err_o` out 2: sticky error flags. [0] overflow, [1] underrun.

## Operation
- Address: `pkg_rd_addr` = {11'd0, `R0_Fbuf`[6:0], `R0_addr`[13:0]} + `ADDR_OFFSET`. The buffer stride is 16 KB.
- State machine states: S_IDLE, S_WAIT, S_REQ, S_DATA.
- S_IDLE: clear `R0_addr` and `R0_bcnt`, then go to S_WAIT.
- S_WAIT: go to S_REQ when `buf_valid_i[R0_Fbuf]`=1 and (`FIFO_DEPTH` − `R0_rcnt_o`) ≥ `PKG_SIZE`.
- S_REQ: assert `pkg_rd_areq` for exactly one cycle, then go to S_DATA.
- S_DATA: each `pkg_rd_en` writes `pkg_rd_data` into the FIFO. On `pkg_rd_last`:
  - `R0_bcnt`++ and `R0_addr` += `BURST_SIZE`.
  - If the new `R0_bcnt` == `BURST_TIMES`: pulse `xdma_irq_req[R0_Fbuf]`, advance `R0_Fbuf` (`FDMA_BUF_SIZE`−1 wraps to 0), go to S_IDLE.
  - Otherwise go to S_WAIT.
- At most one packet is outstanding at any time. Because the space check covers a full packet, overflow cannot occur in correct operation.
- FIFO write happens on `pkg_rd_en`; FIFO read happens on `R0_rden_i` & !`R0_empty_o`.
- Simultaneous read and write: both take effect and the count is unchanged.
- Write while full: the beat is dropped, the count holds, and `err_o[0]` is set.
- Read while empty: ignored, `R0_data_o` holds, and `err_o[1]` is set.
- The `err_o` bits clear only on reset.
- `pkg_rd_en` outside S_DATA: the beat is still written to the FIFO, subject to the full rule. No state change.

## Timing
- Reset values: `pkg_rd_areq`=0, `pkg_rd_addr`=`ADDR_OFFSET`, `xdma_irq_req`=0, `R0_data_o`=0, `R0_empty_o`=1, `R0_rcnt_o`=0, `err_o`=0. State is S_IDLE; `R0_Fbuf`, `R0_addr` and `R0_bcnt` are 0.
- Reset asserted mid-burst: all state and the FIFO are cleared immediately. Beats still arriving are outside this block's scope, because the FDMA engine shares `ui_rstn`.
- S_WAIT condition true at cycle n: `pkg_rd_areq`=1 at cycle n+1 only. `pkg_rd_addr` is stable from S_WAIT until `pkg_rd_last`.
- `R0_data_o` and `R0_rcnt_o` update one cycle after the accepted read or write.
- `R0_empty_o` deasserts one cycle after the first write.
- `xdma_irq_req` pulses in the cycle after `pkg_rd_last`.
- Best-case restart: one idle cycle between packets within a buffer (S_WAIT→S_REQ), and two idle cycles after a buffer change (S_IDLE).

## Configuration
- Macro `FDMA_RD_LOOP_EN`.
- Defined: `buf_valid_i` is ignored and treated as all ones. The block plays the buffer ring cyclically and forever, for waveform-generator playback. `xdma_irq_req` still pulses per buffer.
- Undefined: the `buf_valid_i` gating described under Operation applies.

## Test plan
- Defaults, `buf_valid_i`=2'b01:
  - Expect one `pkg_rd_areq` with `pkg_rd_addr`=0x0 and `pkg_rd_size`=8.
  - After 8 beats ending with `pkg_rd_last`, expect `xdma_irq_req`=2'b01 for one cycle, `R0_rcnt_o`=8, and the next address 0x4000.
  - No further request while `buf_valid_i[1]`=0.
- `buf_valid_i`=2'b11 held, no consumer reads:
  - Expect exactly 4 packets with addresses 0x0, 0x4000, 0x0, 0x4000, then `R0_rcnt_o`=32 and no request.
  - After 8 `R0_rden_i` reads, a request is issued within 2 cycles.
- Data integrity: beat i = {32'hA5A5, i}. Reading out 8 words returns them in order, one cycle after each `R0_rden_i`.
- Error flags:
  - `R0_rden_i` while empty: `err_o`=2'b10, `R0_data_o` unchanged.
  - Force `pkg_rd_en` with the FIFO full: `err_o[0]`=1 and `R0_rcnt_o` stays 32.
- Reset asserted mid-S_DATA after beat 3: all outputs return to their reset values in the same cycle. After release, the first request goes to address 0x0.
- With `FDMA_RD_LOOP_EN` defined and `buf_valid_i`=0: the block issues requests continuously as the consumer drains, with addresses alternating 0x0/0x4000.
